// File: rtl/tqvp_hx2003_pulse_pkg.sv
// ============================================================================
// Module   : tqvp_hx2003_pulse_pkg
// Brief    : Shared types and symbol-format constants for the pulse sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package tqvp_hx2003_pulse_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int SYM_LEVEL_BIT = 1;
    localparam int SYM_SEL_BIT   = 0;
    localparam int SYMS_PER_WORD = 16;
    localparam int SYM_SEL_W     = $clog2(SYMS_PER_WORD);

endpackage

`default_nettype wire

// File: rtl/tqvp_hx2003_tick_prescaler.sv
// ============================================================================
// Module   : tqvp_hx2003_tick_prescaler
// Brief    : Power-of-two divider; one-cycle tick every 2^i_prescaler clocks.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tqvp_hx2003_tick_prescaler #(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic [PRESC_W-1:0] i_prescaler,
    output logic               o_tick
);

    localparam int CNT_W = (1 << PRESC_W) - 1;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_mask;

    // The shift overflows to zero at the largest exponent, so the mask becomes all ones.
    assign w_mask = (CNT_W'(1) << i_prescaler) - CNT_W'(1);
    assign o_tick = (r_cnt & w_mask) == w_mask;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/tqvp_hx2003_pulse_sequencer.sv
// ============================================================================
// Module   : tqvp_hx2003_pulse_sequencer
// Brief    : Plays a 2-bit symbol program from word memory as timed pulses,
//            with optional carrier gating and counted/infinite looping.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tqvp_hx2003_pulse_sequencer
    import tqvp_hx2003_pulse_pkg::*;
#(
    parameter int  NUM_WORDS = 8,
    parameter int  DUR_W     = 8,
    parameter int  PRESC_W   = 4,
    parameter int  CARRIER_W = 16,
    localparam int NSYM      = NUM_WORDS * SYMS_PER_WORD,
    localparam int SYM_W     = $clog2(NSYM),
    localparam int ADDR_W    = $clog2(NUM_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 mem_we,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [SYM_W-1:0]     prog_start,
    input  logic [SYM_W-1:0]     prog_end,
    input  logic                 loop_en,
    input  logic [7:0]           loop_count,
    input  logic [PRESC_W-1:0]   prescaler,
    input  logic [DUR_W-1:0]     dur_low_a,
    input  logic [DUR_W-1:0]     dur_low_b,
    input  logic [DUR_W-1:0]     dur_high_a,
    input  logic [DUR_W-1:0]     dur_high_b,
    input  logic                 carrier_en,
    input  logic [CARRIER_W-1:0] carrier_half,
    input  logic                 idle_level,
    output logic                 pulse_out,
    output logic                 level_out,
    output logic                 busy,
    output logic [SYM_W-1:0]     sym_idx,
    output logic                 done_irq,
    output logic                 loop_irq
);

    state_t               r_state;
    logic [SYM_W-1:0]     r_idx;
    logic [DUR_W-1:0]     r_dur_cnt;
    logic [7:0]           r_passes;
    logic                 r_phase;
    logic [CARRIER_W-1:0] r_car_cnt;
    logic                 r_level;
    logic                 r_pulse;
    logic                 r_done;
    logic                 r_loop;
    logic [31:0]          r_mem [NUM_WORDS];

    state_t               w_next_state;
    logic [SYM_W-1:0]     w_next_idx;
    logic [SYM_W-1:0]     w_idx_inc;
    logic                 w_load;
    logic                 w_enter;
    logic                 w_wrap;
    logic                 w_finish;
    logic                 w_tick;
    logic                 w_boundary;
    logic                 w_loop_ok;
    logic [31:0]          w_word;
    logic [1:0]           w_sym;
    logic [DUR_W-1:0]     w_sym_dur;
    logic                 w_phase_nxt;
    logic                 w_level_nxt;
    logic                 w_pulse_nxt;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            r_mem[mem_addr] <= mem_wdata;
        end
    end

    tqvp_hx2003_tick_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (r_state == IDLE),
        .i_prescaler (prescaler),
        .o_tick      (w_tick)
    );

    assign w_boundary = w_tick && (r_dur_cnt == '0);
    assign w_loop_ok  = loop_en && ((loop_count == 8'd0) || (r_passes < loop_count));
    assign w_idx_inc  = (r_idx == SYM_W'(NSYM - 1)) ? '0 : r_idx + SYM_W'(1);

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_load       = 1'b0;
        w_enter      = 1'b0;
        w_wrap       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    w_next_state = RUN;
                    w_next_idx   = prog_start;
                    w_load       = 1'b1;
                    w_enter      = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    w_next_state = IDLE;
                end else if (w_boundary) begin
                    if (r_idx != prog_end) begin
                        w_next_idx = w_idx_inc;
                        w_load     = 1'b1;
                    end else if (w_loop_ok) begin
                        w_next_idx = prog_start;
                        w_load     = 1'b1;
                        w_wrap     = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                        w_finish     = 1'b1;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // The symbol about to be played is fetched combinationally, so there is no gap between symbols.
    assign w_word    = r_mem[w_next_idx[SYM_W-1:SYM_SEL_W]];
    assign w_sym     = w_word[{w_next_idx[SYM_SEL_W-1:0], 1'b0} +: 2];
    assign w_sym_dur = w_sym[SYM_LEVEL_BIT] ? (w_sym[SYM_SEL_BIT] ? dur_high_b : dur_high_a)
                                            : (w_sym[SYM_SEL_BIT] ? dur_low_b  : dur_low_a);

    assign w_phase_nxt = w_enter ? 1'b1
                       : ((r_state == RUN) && (r_car_cnt == '0)) ? ~r_phase : r_phase;
    assign w_level_nxt = (w_next_state == RUN) ? (w_load ? w_sym[SYM_LEVEL_BIT] : r_level)
                                               : idle_level;
    assign w_pulse_nxt = (w_next_state == RUN) ? (w_level_nxt & (carrier_en ? w_phase_nxt : 1'b1))
                                               : idle_level;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_dur_cnt <= '0;
            r_passes  <= '0;
            r_phase   <= 1'b0;
            r_car_cnt <= '0;
            r_level   <= 1'b0;
            r_pulse   <= 1'b0;
            r_done    <= 1'b0;
            r_loop    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_level <= w_level_nxt;
            r_pulse <= w_pulse_nxt;
            r_done  <= w_finish;
            r_loop  <= w_wrap;
            r_phase <= w_phase_nxt;

            if (w_load) begin
                r_dur_cnt <= w_sym_dur;
            end else if ((r_state == RUN) && w_tick) begin
                r_dur_cnt <= r_dur_cnt - DUR_W'(1);
            end

            if (w_enter) begin
                r_passes <= '0;
            end else if (w_wrap && (r_passes != 8'hFF)) begin
                r_passes <= r_passes + 8'd1;
            end

            // Carrier free-runs across symbol boundaries once playback has started.
            if (w_enter) begin
                r_car_cnt <= carrier_half;
            end else if (r_state == RUN) begin
                r_car_cnt <= (r_car_cnt == '0) ? carrier_half : r_car_cnt - CARRIER_W'(1);
            end
        end
    end

    assign pulse_out = r_pulse;
    assign level_out = r_level;
    assign busy      = (r_state == RUN);
    assign sym_idx   = r_idx;
    assign done_irq  = r_done;
    assign loop_irq  = r_loop;

endmodule

`default_nettype wire

// File: doc/tqvp_hx2003_pulse_sequencer.md
# tqvp_hx2003_pulse_sequencer

Parametrised second-generation pulse transmitter core for TinyQV peripherals. It plays back a programmable sequence of 2-bit symbols stored in an internal word memory. Each symbol selects an output level and one of two durations per level. The output is optionally gated by an on-chip carrier, and the sequence supports counted or infinite looping with completion and loop interrupts. It sits behind the peripheral register wrapper, which drives its configuration ports and memory write port.

## Interface
Parameters:
- NUM_WORDS, 8: number of 32-bit symbol words; each word holds 16 symbols; total symbols NSYM = NUM_WORDS*16.
- DUR_W, 8: width of each duration field.
- PRESC_W, 4: width of the prescaler exponent.
- CARRIER_W, 16: width of the carrier half-period count.
- Derived: SYM_W = $clog2(NSYM).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to begin playback; ignored while busy.
- stop  in  1  one-cycle abort request.
- mem_we  in  1  symbol-memory write strobe.
- mem_addr  in  $clog2(NUM_WORDS)  word address.
- mem_wdata  in  32  word data; symbol k of a word is bits [2k+1:2k].
- prog_start, prog_end  in  SYM_W  first and last symbol index of the program.
- loop_en  in  1  repeat the program after prog_end.
- loop_count  in  8  number of extra passes; 0 means infinite.
- prescaler  in  PRESC_W  duration tick period is 2^prescaler clk cycles.
- dur_low_a, dur_low_b, dur_high_a, dur_high_b  in  DUR_W each  symbol durations, in ticks minus one.
- carrier_en  in  1  gate high symbols with the carrier.
- carrier_half  in  CARRIER_W  carrier half-period, in cycles minus one.
- idle_level  in  1  output level when not busy.
- pulse_out  out  1  modulated output.
- level_out  out  1  unmodulated symbol level.
- busy  out  1  high while playing.
- sym_idx  out  SYM_W  current symbol index.
- done_irq  out  1  one-cycle pulse on normal completion.
- loop_irq  out  1  one-cycle pulse on each wrap to prog_start.

## Operation
- Symbol encoding: bit1 is the level (1 = high), bit0 is the duration select (0 = a, 1 = b).
  - Level 0 uses dur_low_a or dur_low_b; level 1 uses dur_high_a or dur_high_b.
- States: IDLE and RUN.
- IDLE → RUN on start:
  - load sym_idx = prog_start;
  - clear the loop counter;
  - clear the prescaler;
  - set the carrier phase high with its counter = carrier_half.
- RUN, symbol boundary when the duration counter expires:
  - if sym_idx != prog_end, then sym_idx = (sym_idx+1) mod NSYM; wrap-around is allowed, so prog_end < prog_start traverses index NSYM-1 → 0.
  - if sym_idx == prog_end and loop_en is set and (loop_count == 0 or passes < loop_count), then sym_idx = prog_start, passes++ saturating at 255, and loop_irq is pulsed.
  - otherwise go to IDLE and pulse done_irq.
- The memory read is combinational and has no bubble between symbols.
- Memory writes are accepted at any time. A write to a word not yet reached takes effect when that word is played.
- stop in RUN: go to IDLE next cycle with no done_irq. stop in IDLE has no effect.
- start and stop in the same cycle: stop wins, so IDLE stays IDLE.
- A start during RUN is ignored.
- Output logic:
  - level_out = symbol level in RUN, idle_level in IDLE.
  - pulse_out = level_out & (carrier_en ? carrier_phase : 1).
  - The carrier toggles every carrier_half+1 cycles while in RUN and free-runs across symbols.
- Configuration inputs are sampled live. Software changes them only while not busy; behaviour when they change mid-run is defined only as "takes effect at the next use".

## Timing
- Reset values: pulse_out 0, level_out 0, busy 0, sym_idx 0, done_irq 0, loop_irq 0, state IDLE, memory contents undefined. Reset mid-run aborts immediately.
- A start sampled at edge T gives busy=1 and a valid level_out for prog_start from T+1.
- Each symbol lasts exactly (dur+1)*2^prescaler cycles.
- done_irq and loop_irq are asserted for exactly one cycle, coincident with the first cycle of IDLE or of the re-entered prog_start symbol respectively.
- In the cycle busy falls, pulse_out = idle_level.

## Structure
- Package tqvp_hx2003_pulse_pkg holds:
  - the state enum (IDLE, RUN);
  - symbol field positions (SYM_LEVEL_BIT=1, SYM_SEL_BIT=0);
  - SYMS_PER_WORD=16.
- Sub-module tqvp_hx2003_tick_prescaler: PRESC_W-exponent divider with synchronous clear, emitting a one-cycle tick every 2^prescaler cycles.
- The carrier generator and duration counter are inline.

## Test plan
- Single pass:
  - setup: word0 = 32'h0000_00E4 (symbols 0,1,2,3 = low-a, low-b, high-a, high-b); durations 1,2,3,4; prescaler 0; prog 0..3; loop_en=0.
  - response: level_out low for 2+3 cycles, then high for 4+5 cycles; done_irq at T+15; busy low afterwards.
- Prescaler:
  - setup: same program, prescaler=2.
  - response: every duration ×4; total 56 cycles.
- Counted loop:
  - setup: loop_en=1, loop_count=2.
  - response: 3 passes; 2 loop_irq pulses spaced 14 cycles apart, then done_irq.
- Wrap-around and carrier:
  - setup: prog_start=NSYM-2, prog_end=1; carrier_en=1, carrier_half=0.
  - response: sym_idx sequence is 126, 127, 0, 1; pulse_out toggles every cycle during high symbols and stays 0 during low symbols.
- Abort:
  - stimulus: stop at cycle 5 of an infinite loop.
  - response: busy=0 and pulse_out=idle_level next cycle; no done_irq.
  - stimulus: start and stop together in IDLE.
  - response: stays IDLE.
- Reset mid-run:
  - stimulus: rst_n low for 1 cycle during RUN.
  - response: all outputs at reset values next cycle.
